// File: rtl/ringbuffer_sched_pkg.sv
// Shared types and helpers for the capture ringbuffer scheduler:
// write/read FSM state encodings and the drop-marker record builder.
`default_nettype none

package ringbuffer_sched_pkg;

    typedef enum logic [0:0] {
        W_IDLE  = 1'b0,
        W_WRITE = 1'b1
    } wr_state_t;

    typedef enum logic [1:0] {
        R_IDLE    = 2'd0,
        R_FETCH   = 2'd1,
        R_PRESENT = 2'd2,
        R_ADVANCE = 2'd3
    } rd_state_t;

    localparam logic [7:0] DROP_TAG_DEFAULT = 8'hFF;
    localparam int         MARKER_MAX_W     = 128;

    // Builds {tag, zero-extended count} left-aligned to an entry of width dw;
    // callers truncate the result to their own entry width.
    function automatic logic [MARKER_MAX_W-1:0] build_marker(
        input logic [7:0]              tag,
        input logic [MARKER_MAX_W-1:0] count,
        input int unsigned             dw
    );
        logic [MARKER_MAX_W-1:0] m;
        m = count | ({{(MARKER_MAX_W-8){1'b0}}, tag} << (dw - 8));
        return m;
    endfunction

endpackage

`default_nettype wire

// File: rtl/ringbuffer_scheduler_rr_arbiter2.sv
// Two-way round-robin arbiter; the last-grant register moves only when the
// caller reports that the current grant was consumed.
`default_nettype none

module rr_arbiter2 (
    input  logic       clock,
    input  logic       reset,
    input  logic [1:0] req_i,
    input  logic       advance_i,
    output logic [1:0] grant_o
);

    // Set means requester 1 was granted last, so requester 0 wins the next tie.
    logic last_q;

    always_comb begin
        grant_o = req_i;
        if (req_i == 2'b11) begin
            grant_o = last_q ? 2'b01 : 2'b10;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            last_q <= 1'b1;
        end else if (advance_i) begin
            last_q <= grant_o[1];
        end
    end

endmodule

`default_nettype wire

// File: rtl/ringbuffer_scheduler.sv
// Sequences the shared capture ringbuffer: arbitrates two producers into RAM,
// records overflow losses as a single drop marker, and drains to a consumer.
`default_nettype none

module ringbuffer_scheduler
    import ringbuffer_sched_pkg::*;
#(
    parameter int         AW       = 4,
    parameter int         DW       = 48,
    parameter int         CW       = 16,
    parameter logic [7:0] DROP_TAG = DROP_TAG_DEFAULT
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          p0_valid,
    input  logic [DW-1:0] p0_data,
    output logic          p0_ready,
    input  logic          p1_valid,
    input  logic [DW-1:0] p1_data,
    output logic          p1_ready,
    input  logic [AW-1:0] rb_write_ptr,
    input  logic [AW-1:0] rb_read_ptr,
    input  logic          rb_empty,
    input  logic          rb_overflow,
    output logic          rb_write_clock_enable,
    output logic          rb_read_clock_enable,
    output logic          mem_we,
    output logic [AW-1:0] mem_waddr,
    output logic [DW-1:0] mem_wdata,
    output logic [AW-1:0] mem_raddr,
    input  logic [DW-1:0] mem_rdata,
    output logic          out_valid,
    output logic [DW-1:0] out_data,
    input  logic          out_ready,
    output logic [CW-1:0] drop_count
);

    wr_state_t     w_state_q;
    logic [DW-1:0] wdata_q;
    logic          marker_q;
    logic [CW-1:0] drop_count_q;

    rd_state_t     r_state_q;
    logic [DW-1:0] out_data_q;

    logic [1:0]    w_grant;
    logic          w_idle;
    logic          w_do_marker;
    logic          w_take;
    logic [DW-1:0] w_sel_data;
    logic [DW-1:0] w_marker;

    // Gating with reset keeps the combinational readies low while reset is held.
    assign w_idle      = reset && (w_state_q == W_IDLE);
    assign w_do_marker = w_idle && (drop_count_q != '0) && !rb_overflow;
    assign w_take      = w_idle && !w_do_marker && (p0_valid || p1_valid);
    assign w_sel_data  = w_grant[1] ? p1_data : p0_data;
    assign w_marker    = DW'(build_marker(DROP_TAG, MARKER_MAX_W'(drop_count_q), DW));

    rr_arbiter2 u_arb (
        .clock     (clock),
        .reset     (reset),
        .req_i     ({p1_valid, p0_valid}),
        .advance_i (w_take),
        .grant_o   (w_grant)
    );

    assign p0_ready = w_take && w_grant[0];
    assign p1_ready = w_take && w_grant[1];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            w_state_q    <= W_IDLE;
            wdata_q      <= '0;
            marker_q     <= 1'b0;
            drop_count_q <= '0;
        end else begin
            case (w_state_q)
                W_IDLE: begin
                    if (w_do_marker) begin
                        wdata_q   <= w_marker;
                        marker_q  <= 1'b1;
                        w_state_q <= W_WRITE;
                    end else if (w_take) begin
                        if (!rb_overflow) begin
                            wdata_q   <= w_sel_data;
                            marker_q  <= 1'b0;
                            w_state_q <= W_WRITE;
                        end else if (drop_count_q != '1) begin
                            drop_count_q <= drop_count_q + CW'(1);
                        end
                    end
                end
                W_WRITE: begin
                    if (marker_q) begin
                        drop_count_q <= '0;
                    end
                    marker_q  <= 1'b0;
                    w_state_q <= W_IDLE;
                end
                default: w_state_q <= W_IDLE;
            endcase
        end
    end

    assign mem_we                = (w_state_q == W_WRITE);
    assign rb_write_clock_enable = (w_state_q == W_WRITE);
    assign mem_waddr             = rb_write_ptr;
    assign mem_wdata             = wdata_q;
    assign drop_count            = drop_count_q;

    // R_FETCH covers the RAM's one-cycle registered read latency.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state_q  <= R_IDLE;
            out_data_q <= '0;
        end else begin
            case (r_state_q)
                R_IDLE: begin
                    if (!rb_empty) begin
                        r_state_q <= R_FETCH;
                    end
                end
                R_FETCH: begin
                    out_data_q <= mem_rdata;
                    r_state_q  <= R_PRESENT;
                end
                R_PRESENT: begin
                    if (out_ready) begin
                        r_state_q <= R_ADVANCE;
                    end
                end
                R_ADVANCE: r_state_q <= R_IDLE;
                default:   r_state_q <= R_IDLE;
            endcase
        end
    end

    assign mem_raddr            = rb_read_ptr;
    assign out_valid            = (r_state_q == R_PRESENT);
    assign out_data             = out_data_q;
    assign rb_read_clock_enable = (r_state_q == R_ADVANCE);

endmodule

`default_nettype wire

// File: tb/tb_ringbuffer_scheduler.sv
// Scoreboard bench for ringbuffer_scheduler: a pointer/flag ringbuffer and RAM
// surround the DUT; a reference model predicts the drained stream.
`default_nettype none

module tb_ringbuffer_scheduler;

    localparam int AW = 2;
    localparam int DW = 48;
    localparam int CW = 16;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          p0_valid = 1'b0, p1_valid = 1'b0;
    logic [DW-1:0] p0_data = '0, p1_data = '0;
    logic          p0_ready, p1_ready;
    logic [AW-1:0] wp, rp;
    logic          rb_empty, rb_overflow;
    logic          rb_write_clock_enable, rb_read_clock_enable;
    logic          mem_we;
    logic [AW-1:0] mem_waddr, mem_raddr;
    logic [DW-1:0] mem_wdata, mem_rdata;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic          out_ready = 1'b0;
    logic [CW-1:0] drop_count;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clock = ~clock;

    ringbuffer_scheduler #(.AW(AW), .DW(DW), .CW(CW), .DROP_TAG(8'hFF)) dut (
        .clock(clock), .reset(reset),
        .p0_valid(p0_valid), .p0_data(p0_data), .p0_ready(p0_ready),
        .p1_valid(p1_valid), .p1_data(p1_data), .p1_ready(p1_ready),
        .rb_write_ptr(wp), .rb_read_ptr(rp), .rb_empty(rb_empty), .rb_overflow(rb_overflow),
        .rb_write_clock_enable(rb_write_clock_enable), .rb_read_clock_enable(rb_read_clock_enable),
        .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
        .mem_raddr(mem_raddr), .mem_rdata(mem_rdata),
        .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
        .drop_count(drop_count)
    );

    // Environment: ringbuffer pointers/flags and a RAM with registered read.
    logic [DW-1:0] mem [0:(1<<AW)-1];

    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            wp <= '0;
            rp <= '0;
        end else begin
            if (rb_write_clock_enable) wp <= wp + AW'(1);
            if (rb_read_clock_enable)  rp <= rp + AW'(1);
        end
    end

    assign rb_empty    = (wp == rp);
    assign rb_overflow = ((wp + AW'(1)) == rp);

    always @(posedge clock) begin
        if (mem_we) mem[mem_waddr] <= mem_wdata;
        mem_rdata <= mem[mem_raddr];
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    endtask

    function automatic logic [DW-1:0] rand_word();
        logic [63:0] r;
        r = {$urandom(), $urandom()};
        return r[DW-1:0];
    endfunction

    function automatic logic [DW-1:0] marker_of(input int unsigned cnt);
        logic [DW-1:0] m;
        m = DW'(cnt);
        m[DW-1 -: 8] = 8'hFF;
        return m;
    endfunction

    // Reference model: the stream the consumer should see, plus pending drops.
    logic [DW-1:0] exp_q[$];
    int unsigned   model_drops = 0;
    int            last_grant  = 1;

    always @(negedge clock) begin
        logic [DW-1:0] e;
        logic [DW-1:0] d;
        int g;
        if (!reset) begin
            exp_q.delete();
            model_drops = 0;
            last_grant  = 1;
        end else begin
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_out: got %h, expected no entry at %0t", out_data, $time);
                end else begin
                    e = exp_q.pop_front();
                    check("out_data", 64'(out_data), 64'(e));
                end
            end
            // Lost entries surface as one marker once the buffer has room again.
            if (model_drops != 0 && !rb_overflow) begin
                exp_q.push_back(marker_of(model_drops));
                model_drops = 0;
            end
            if (p0_ready || p1_ready) begin
                if (p0_valid && p1_valid) g = (last_grant == 1) ? 0 : 1;
                else                      g = p0_valid ? 0 : 1;
                check("grant", 64'({p1_ready, p0_ready}), (g == 0) ? 64'd1 : 64'd2);
                last_grant = g;
                d = (g == 0) ? p0_data : p1_data;
                if (rb_overflow) begin
                    if (model_drops < 32'hFFFF) model_drops++;
                end else begin
                    exp_q.push_back(d);
                end
            end
        end
    end

    task automatic send0(input logic [DW-1:0] d);
        bit got;
        got = 0;
        p0_data  = d;
        p0_valid = 1'b1;
        for (int k = 0; k < 50 && !got; k++) begin
            @(negedge clock);
            if (p0_ready) got = 1;
        end
        check("send0_handshake", 64'(got), 64'd1);
        @(posedge clock); #1;
        p0_valid = 1'b0;
    endtask

    task automatic drain();
        p0_valid  = 1'b0;
        p1_valid  = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 400; k++) begin
            @(negedge clock);
            if (exp_q.size() == 0 && model_drops == 0 && rb_empty && !out_valid) break;
        end
        check("drain_pending", 64'(exp_q.size() + model_drops), 64'd0);
        @(posedge clock); #1;
    endtask

    task automatic run_random(input int cycles, input int pv, input int pr);
        bit hs0, hs1;
        for (int c = 0; c < cycles; c++) begin
            @(negedge clock);
            hs0 = p0_valid && p0_ready;
            hs1 = p1_valid && p1_ready;
            @(posedge clock); #1;
            if (!p0_valid || hs0) begin
                p0_valid = ($urandom_range(0, 99) < pv);
                p0_data  = rand_word();
            end
            if (!p1_valid || hs1) begin
                p1_valid = ($urandom_range(0, 99) < pv);
                p1_data  = rand_word();
            end
            out_ready = ($urandom_range(0, 99) < pr);
        end
    endtask

    initial begin
        logic [AW-1:0] wp_before;
        logic [DW-1:0] held;
        int lat, bad, pulses;
        bit got;

        // Reset held with both producers requesting.
        p0_valid = 1'b1; p0_data = 48'h0000_0000_0011;
        p1_valid = 1'b1; p1_data = 48'h0000_0000_0022;
        repeat (3) @(negedge clock);
        check("reset_ready", 64'({p1_ready, p0_ready}), 64'd0);
        check("reset_out_valid", 64'(out_valid), 64'd0);
        check("reset_enables", 64'({rb_write_clock_enable, rb_read_clock_enable, mem_we}), 64'd0);
        check("reset_drop_count", 64'(drop_count), 64'd0);
        check("reset_out_data", 64'(out_data), 64'd0);
        @(posedge clock); #1;
        reset = 1'b1;
        @(negedge clock);
        check("first_grant", 64'({p1_ready, p0_ready}), 64'd1);
        @(posedge clock); #1;
        p0_valid = 1'b0;
        got = 0;
        for (int k = 0; k < 20 && !got; k++) begin
            @(negedge clock);
            if (p1_ready) got = 1;
        end
        check("p1_handshake", 64'(got), 64'd1);
        @(posedge clock); #1;
        p1_valid = 1'b0;
        drain();

        // Single entry into an empty buffer; measure drain latency, then hold.
        out_ready = 1'b0;
        wp_before = wp;
        p0_data   = 48'h0000_0000_00AA;
        p0_valid  = 1'b1;
        @(negedge clock);
        check("aa_ready", 64'(p0_ready), 64'd1);
        @(posedge clock); #1;
        p0_valid = 1'b0;
        @(negedge clock);
        check("aa_write", 64'({mem_we, mem_waddr}), 64'({1'b1, wp_before}));
        @(negedge clock);
        check("aa_empty_fell", 64'(rb_empty), 64'd0);
        lat = 0;
        while (!out_valid && lat < 10) begin
            @(negedge clock);
            lat++;
        end
        check("drain_latency", 64'(lat), 64'd2);
        check("aa_present", 64'(out_data), 64'h0000_0000_00AA);
        held = out_data;
        bad  = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clock);
            if (out_data !== held || !out_valid || rb_read_clock_enable) bad++;
        end
        check("hold_stable", 64'(bad), 64'd0);
        @(posedge clock); #1 out_ready = 1'b1;
        @(posedge clock); #1 out_ready = 1'b0;
        pulses = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clock);
            if (rb_read_clock_enable) pulses++;
        end
        check("read_pulses", 64'(pulses), 64'd1);
        drain();

        // Fill the 3-entry buffer, drop two, free one slot and expect the marker.
        out_ready = 1'b0;
        send0(48'h0000_0000_0101);
        send0(48'h0000_0000_0102);
        send0(48'h0000_0000_0103);
        send0(48'h0000_0000_0104);
        send0(48'h0000_0000_0105);
        @(negedge clock);
        check("drop_count_2", 64'(drop_count), 64'd2);
        @(posedge clock); #1 out_ready = 1'b1;
        @(negedge clock);
        @(posedge clock); #1 out_ready = 1'b0;
        @(posedge clock); #1;
        p0_data  = 48'h0000_0000_0106;
        p0_valid = 1'b1;
        @(negedge clock);
        check("marker_priority", 64'(p0_ready), 64'd0);
        @(negedge clock);
        check("marker_write", 64'({mem_we, mem_wdata}), 64'({1'b1, 48'hFF00_0000_0002}));
        @(negedge clock);
        check("drop_count_clear", 64'(drop_count), 64'd0);
        got = p0_ready;
        for (int k = 0; k < 20 && !got; k++) begin
            @(negedge clock);
            if (p0_ready) got = 1;
        end
        check("post_marker_handshake", 64'(got), 64'd1);
        @(posedge clock); #1;
        p0_valid = 1'b0;
        drain();

        // Both producers held valid: grants must alternate.
        run_random(60, 100, 100);
        drain();
        run_random(1500, 40, 50);
        drain();

        // Asynchronous reset while presenting and writing.
        out_ready = 1'b0;
        send0(rand_word());
        for (int k = 0; k < 20 && !out_valid; k++) @(negedge clock);
        @(posedge clock); #1;
        p0_data  = rand_word();
        p0_valid = 1'b1;
        @(negedge clock);
        check("pre_reset_ready", 64'(p0_ready), 64'd1);
        @(posedge clock); #1;
        check("pre_reset_state", 64'({mem_we, out_valid}), 64'd3);
        #2 reset = 1'b0;
        #1;
        check("async_reset", 64'({mem_we, out_valid, rb_write_clock_enable, rb_read_clock_enable}), 64'd0);
        repeat (2) @(posedge clock);
        #1;
        p0_valid = 1'b0;
        reset    = 1'b1;
        @(negedge clock);
        check("restart_idle", 64'({mem_we, out_valid, drop_count}), 64'd0);
        send0(48'h0000_0000_0BEE);
        drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

endmodule

`default_nettype wire
